chunked_add_sub: RTL and testbench

CHUNKED_ADD_SUB -- requirements
Module: chunked_add_sub

---
 rtl/chunked_add_sub_if.sv | 24 ++
 rtl/chunked_add_sub.sv | 104 ++++++++++
 tb/tb_chunked_add_sub.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/chunked_add_sub_if.sv
// Operand/result handshake bundle for chunked_add_sub; master drives operations, slave computes.
interface chunked_add_sub_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Ci, Sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Ci, Sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
endinterface

// File: rtl/chunked_add_sub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB first.
// Optional signed saturation on overflow when ADD_SUB_SAT_EN is defined.
module chunked_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst,
  chunked_add_sub_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [CHUNK-1:0] ca, cb, cs;
  logic             cc, last, msb_cin;

  // Subtraction is folded in at capture: B is inverted and the carry-in flipped.
  always_comb begin
    ca        = a_q[cnt_q*CHUNK +: CHUNK];
    cb        = b_q[cnt_q*CHUNK +: CHUNK];
    {cc, cs}  = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, c_q};
    last      = (cnt_q == CW'(NCHUNK - 1));
    // On the last chunk cs[CHUNK-1] is bit WIDTH-1, so this recovers its carry-in.
    msb_cin   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ cs[CHUNK-1];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.B ^ {WIDTH{bus.Sub}};
          c_d     = bus.Ci ^ bus.Sub;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[cnt_q*CHUNK +: CHUNK] = cs;
        c_d   = cc;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          cout_d  = cc;
          ovf_d   = cc ^ msb_cin;
`ifdef ADD_SUB_SAT_EN
          if (cc ^ msb_cin)
            sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_chunked_add_sub.sv
// Directed bench for chunked_add_sub: 8/4 directed vectors, then random sweeps on 16/4 and 8/8.
module tb_chunked_add_sub;
`ifdef ADD_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a_tb = '0, b_tb = '0;
  logic        ci_tb = 1'b0, sub_tb = 1'b0;
  logic [2:0]  iv = '0, ordy = '0;
  int          compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  chunked_add_sub_if #(.WIDTH(8))  if8 ();
  chunked_add_sub_if #(.WIDTH(16)) if16 ();
  chunked_add_sub_if #(.WIDTH(8))  if88 ();

  assign if8.A  = a_tb[7:0];  assign if8.B  = b_tb[7:0];
  assign if16.A = a_tb;       assign if16.B = b_tb;
  assign if88.A = a_tb[7:0];  assign if88.B = b_tb[7:0];
  assign if8.Ci = ci_tb;  assign if16.Ci = ci_tb;  assign if88.Ci = ci_tb;
  assign if8.Sub = sub_tb; assign if16.Sub = sub_tb; assign if88.Sub = sub_tb;
  assign if8.in_valid = iv[0];   assign if16.in_valid = iv[1];   assign if88.in_valid = iv[2];
  assign if8.out_ready = ordy[0]; assign if16.out_ready = ordy[1]; assign if88.out_ready = ordy[2];

  chunked_add_sub #(.WIDTH(8),  .CHUNK(4)) u8  (.clk(clk), .rst(rst), .bus(if8));
  chunked_add_sub #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst(rst), .bus(if16));
  chunked_add_sub #(.WIDTH(8),  .CHUNK(8)) u88 (.clk(clk), .rst(rst), .bus(if88));

  logic [2:0]  ovv, irv, cov, ofv;
  logic [15:0] sumv [3];
  assign ovv = {if88.out_valid, if16.out_valid, if8.out_valid};
  assign irv = {if88.in_ready,  if16.in_ready,  if8.in_ready};
  assign cov = {if88.Cout,      if16.Cout,      if8.Cout};
  assign ofv = {if88.Ovf,       if16.Ovf,       if8.Ovf};
  assign sumv[0] = {8'h00, if8.Sum};
  assign sumv[1] = if16.Sum;
  assign sumv[2] = {8'h00, if88.Sum};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sub,
                       output logic [15:0] s, output logic co, output logic ov, output int lat);
    a_tb = a; b_tb = b; ci_tb = ci; sub_tb = sub; iv[w] = 1'b1;
    @(posedge clk); #1;
    iv[w] = 1'b0; lat = 0;
    while (!ovv[w] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sumv[w]; co = cov[w]; ov = ofv[w];
    ordy[w] = 1'b1;
    @(posedge clk); #1;
    ordy[w] = 1'b0;
  endtask

  // Reference: plain integer arithmetic, signed range check for overflow.
  task automatic ref_op(input int width, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sub,
                        output logic [15:0] s, output logic co, output logic ov);
    longint mask, u, sa, sb, sr;
    mask = (64'sd1 <<< width) - 1;
    sa = longint'(a) & mask; if (sa >= (64'sd1 <<< (width-1))) sa -= (64'sd1 <<< width);
    sb = longint'(b) & mask; if (sb >= (64'sd1 <<< (width-1))) sb -= (64'sd1 <<< width);
    if (!sub) begin
      u  = (longint'(a) & mask) + (longint'(b) & mask) + longint'(ci);
      sr = sa + sb + longint'(ci);
    end else begin
      u  = (longint'(a) & mask) + (mask - (longint'(b) & mask)) + 1 - longint'(ci);
      sr = sa - sb - longint'(ci);
    end
    co = u[width];
    ov = (sr > (64'sd1 <<< (width-1)) - 1) || (sr < -(64'sd1 <<< (width-1)));
    s  = 16'(u & mask);
    if (SAT && ov) s = a[width-1] ? 16'(64'sd1 <<< (width-1)) : 16'(mask >>> 1);
  endtask

  task automatic sweep(input int w, input int width, input int nch, input int n);
    logic [15:0] a, b, s, es;
    logic ci, sub, co, ov, eco, eov;
    int lat;
    for (int i = 0; i < n; i++) begin
      case (i % 4)
        0: begin a = 16'($urandom); b = 16'($urandom); end
        1: begin a = 16'hFFFF; b = 16'($urandom); end
        2: begin a = 16'(1 << (width-1)); b = 16'($urandom_range(0, 3)); end
        default: begin a = 16'($urandom); b = a; end
      endcase
      if (width == 8) begin a[15:8] = '0; b[15:8] = '0; end
      ci = 1'($urandom); sub = 1'($urandom);
      ref_op(width, a, b, ci, sub, es, eco, eov);
      do_op(w, a, b, ci, sub, s, co, ov, lat);
      chk($sformatf("sweep%0d {Cout,Sum} a=%h b=%h ci=%b sub=%b", w, a, b, ci, sub),
          {15'd0, co, s}, {15'd0, eco, es});
      chk($sformatf("sweep%0d Ovf", w), {31'd0, ov}, {31'd0, eov});
      chk($sformatf("sweep%0d latency", w), lat, nch);
    end
  endtask

  initial begin
    logic [15:0] s;
    logic co, ov;
    int lat;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", {29'd0, ovv}, 32'd0);
    chk("rst Sum", {16'd0, sumv[0]}, 32'd0);
    chk("rst Cout/Ovf", {30'd0, cov[0], ofv[0]}, 32'd0);
    rst = 1'b0;
    chk("rst in_ready", {29'd0, irv}, 32'h7);

    do_op(0, 16'd255, 16'd8, 1'b0, 1'b0, s, co, ov, lat);
    chk("add 255+8 Sum", s, 16'h07);
    chk("add 255+8 Cout/Ovf", {co, ov}, 2'b10);
    chk("add 255+8 latency", lat, 2);

    do_op(0, 16'd170, 16'd170, 1'b1, 1'b0, s, co, ov, lat);
    chk("add 170+170+1 Sum", s, SAT ? 16'h80 : 16'h55);
    chk("add 170+170+1 Cout/Ovf", {co, ov}, 2'b11);

    do_op(0, 16'd5, 16'd8, 1'b0, 1'b1, s, co, ov, lat);
    chk("sub 5-8 Sum", s, 16'hFD);
    chk("sub 5-8 Cout/Ovf", {co, ov}, 2'b00);

    do_op(0, 16'd127, 16'd1, 1'b0, 1'b0, s, co, ov, lat);
    chk("add 127+1 Sum", s, SAT ? 16'h7F : 16'h80);
    chk("add 127+1 Cout/Ovf", {co, ov}, 2'b01);

    do_op(0, 16'h80, 16'h01, 1'b1, 1'b1, s, co, ov, lat);
    chk("sub 0x80-1-1 Sum", s, SAT ? 16'h80 : 16'h7E);
    chk("sub 0x80-1-1 Cout/Ovf", {co, ov}, 2'b11);

    do_op(0, 16'h3C, 16'h3C, 1'b0, 1'b1, s, co, ov, lat);
    chk("sub equal Sum", s, 16'h00);
    chk("sub equal Cout/Ovf", {co, ov}, 2'b10);

    // Back-pressure with operand changes during BUSY
    a_tb = 16'h12; b_tb = 16'h34; ci_tb = 1'b0; sub_tb = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0; a_tb = 16'hFF; b_tb = 16'hFF; sub_tb = 1'b1; ci_tb = 1'b1;
    chk("bp busy0 in_ready/out_valid", {irv[0], ovv[0]}, 2'b00);
    @(posedge clk); #1;
    a_tb = 16'h00;
    chk("bp busy1 in_ready/out_valid", {irv[0], ovv[0]}, 2'b00);
    @(posedge clk); #1;
    chk("bp done Sum", sumv[0], 16'h46);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d Sum", i), sumv[0], 16'h46);
      chk($sformatf("bp hold%0d in_ready/out_valid/Cout/Ovf", i),
          {irv[0], ovv[0], cov[0], ofv[0]}, 4'b0100);
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    chk("bp release in_ready/out_valid", {irv[0], ovv[0]}, 2'b10);

    // Reset during BUSY aborts the operation
    a_tb = 16'hFF; b_tb = 16'hFF; ci_tb = 1'b1; sub_tb = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("busy rst out_valid", {31'd0, ovv[0]}, 32'd0);
    chk("busy rst Sum", sumv[0], 16'h00);
    chk("busy rst in_ready", {31'd0, irv[0]}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("busy rst no late out_valid", {31'd0, ovv[0]}, 32'd0);

    // Single-chunk variant
    do_op(2, 16'h7F, 16'h01, 1'b0, 1'b0, s, co, ov, lat);
    chk("8/8 127+1 Sum", s, SAT ? 16'h7F : 16'h80);
    chk("8/8 127+1 Cout/Ovf", {co, ov}, 2'b01);
    chk("8/8 latency", lat, 1);

    sweep(1, 16, 4, 40);
    sweep(2, 8, 1, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
